matmul_dot_scheduler: RTL and testbench
=======================================

# matmul_dot_scheduler

Sequencer that computes every entry of an M×P matrix product by issuing (row, col) index pairs, in row-major order, to one shared scalar-product engine. The engine has fixed latency. The block tags each issue, captures the engine result LAT cycles later, and buffers it in a small output FIFO. Results leave on a valid/ready stream, and a credit scheme makes back-pressure lossless. It sits between the operand memories (addressed by the issued indices) and the result writer of the matmul top level.

## Interface
- Nbits, 4, operand width; results are 2*Nbits wide.
- M, 4, number of result rows (rows of A).
- P, 4, number of result columns (columns of B).
- LAT, 2, engine latency: cycles from an issue cycle to the cycle its result is valid on eng_result. Must be ≥ 1.
- clk  input  1  single clock; everything is on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the clk edge; 0 = reset.
- start  input  1  job request; sampled only in IDLE.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the last result of a job has been accepted downstream.
- issue_valid  output  1  an index pair is issued this cycle.
- issue_row  output  $clog2(M) (minimum 1)  row index of A for the issued pair.
- issue_col  output  $clog2(P) (minimum 1)  column index of B for the issued pair.
- eng_result  input  2*Nbits  engine output; meaningful LAT cycles after the matching issue.
- res_valid  output  1  FIFO head is valid.
- res_ready  input  1  consumer accepts the head when res_valid is also high.
- res_row, res_col  output  same widths as issue_row / issue_col  index tag of the head.
- res_data  output  2*Nbits  dot-product value of the head.

## Operation
- States:
  - IDLE: start=1 → RUN; issue counter cleared to (0,0).
  - RUN: issues pairs; after the issue of (M-1,P-1) → DRAIN.
  - DRAIN: no issues; waits until the in-flight count and the FIFO count are both 0 → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- start is ignored outside IDLE; it is level-sampled, so start held high in IDLE launches back-to-back jobs.
- Issue order is row-major with col fastest: (0,0), (0,1) … (0,P-1), (1,0) … (M-1,P-1). Exactly M*P issues per job.
- Tag pipeline: a LAT-stage shift register carries {valid, row, col} for each issue. When stage LAT is valid, eng_result is written into the FIFO with that tag.
- FIFO depth D = LAT+2; entries are {row, col, data}; first in, first out; res_* present the head.
- Credit rule: in RUN, issue only when inflight + fifo_count < D. Both counts are registered values; a pop in the same cycle gives no credit. Every tagged result therefore always has a FIFO slot, so overflow is impossible.
- Counts:
  - inflight: +1 on an issue, −1 on a capture.
  - fifo_count: +1 on a capture, −1 on a pop; simultaneous push and pop leaves it unchanged.
- Arithmetic: data passes through unmodified; the 2*Nbits width is kept and nothing is truncated or extended.
- Reset (reset=0, at any time, including mid-job): state ← IDLE; counters, tag pipeline and FIFO are cleared; in-flight results are discarded.
- Reset values of outputs: busy=0, done=0, issue_valid=0, issue_row=0, issue_col=0, res_valid=0, res_row=0, res_col=0, res_data=0.
- res_valid never drops while res_ready=0; head contents stay stable until popped.

## Timing
- start seen high in IDLE at edge t: busy=1 and the first issue_valid (0,0) in cycle t+1.
- Result of an issue in cycle k: captured at the end of cycle k+LAT; res_valid with that entry no earlier than cycle k+LAT+1.
- res_ready held high: one issue and one result per cycle. Last issue in cycle t+M*P; last result popped in cycle t+M*P+LAT+1; done=1 and busy=0 in cycle t+M*P+LAT+2; IDLE again from cycle t+M*P+LAT+3.
- res_ready low: issues stop once inflight + fifo_count reaches D. The issue counter holds and issue_valid=0 while stalled. Issuing resumes the cycle after a pop frees a credit.
- M*P=1: one issue, then DRAIN directly.
- done and a new start: start is sampled only once the FSM is back in IDLE, which is one cycle after done.

## Test plan
- M=2, P=3, LAT=2; drive eng_result = 10*row+col, correctly delayed; res_ready=1 → six results in order 0, 1, 2, 10, 11, 12 in consecutive cycles. done occurs 2+6+2 = 10 cycles after the start edge (t+M*P+LAT+2, with M*P=6, LAT=2).
- Same job with res_ready=0 from cycle 1 → exactly 4 issues (D=4), then issue_valid=0; res_valid=1 holds value 0 stable. Release res_ready → remaining 2 issues follow; all six values arrive, none lost or duplicated.
- res_ready toggling 1,0,1,0 randomly over 1000 jobs at M=P=4 → scoreboard matches; FIFO never overflows; done pulses once per job.
- reset=0 asserted in the cycle of the third issue → next cycle all outputs are at reset values. A later start gives a clean job from (0,0), with no stale results.
- start held high across two jobs, M=P=1 → issue (0,0); done; the second job's issue comes 2 cycles after done (DONE→IDLE→RUN).
- start pulsed during RUN → ignored; the issue count stays M*P.

Source files
------------

// File: rtl/matmul_dot_scheduler.sv
// matmul_dot_scheduler: issues row-major (row, col) pairs to a fixed-latency
// dot-product engine and returns the tagged results through a credit-guarded FIFO.
module matmul_dot_scheduler #(
  parameter int Nbits = 4,
  parameter int M = 4,
  parameter int P = 4,
  parameter int LAT = 2,
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int CLW = (P > 1) ? $clog2(P) : 1,
  localparam int DW = 2 * Nbits
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           issue_valid,
  output logic [RW-1:0]  issue_row,
  output logic [CLW-1:0] issue_col,
  input  logic [DW-1:0]  eng_result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [RW-1:0]  res_row,
  output logic [CLW-1:0] res_col,
  output logic [DW-1:0]  res_data
);

  localparam int D = LAT + 2;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [CW:0] D_LIMIT = (CW + 1)'(D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r, state_s;
  logic [RW-1:0]  row_r, row_s;
  logic [CLW-1:0] col_r, col_s;
  logic           issue_valid_r, issue_next_s;
  logic           busy_r, done_r, res_valid_r;
  logic [CW-1:0]  inflight_r, inflight_s;
  logic [CW-1:0]  fifo_count_r, fifo_count_s;
  logic           issue_s, capture_s, pop_s, last_s, credit_s;

  logic           tag_valid_r [LAT];
  logic [RW-1:0]  tag_row_r   [LAT];
  logic [CLW-1:0] tag_col_r   [LAT];

  logic [RW-1:0]  mem_row_r  [D];
  logic [CLW-1:0] mem_col_r  [D];
  logic [DW-1:0]  mem_data_r [D];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;

  assign issue_s   = issue_valid_r;
  assign capture_s = tag_valid_r[LAT-1];
  assign pop_s     = res_valid_r && res_ready;
  assign last_s    = (row_r == RW'(M - 1)) && (col_r == CLW'(P - 1));

  // Counts as they will stand after this edge; the issue decision for the next
  // cycle is taken on them so issue_valid can be a plain register.
  assign inflight_s   = inflight_r + {{(CW-1){1'b0}}, issue_s} - {{(CW-1){1'b0}}, capture_s};
  assign fifo_count_s = fifo_count_r + {{(CW-1){1'b0}}, capture_s} - {{(CW-1){1'b0}}, pop_s};
  assign credit_s     = ({1'b0, inflight_s} + {1'b0, fifo_count_s}) < D_LIMIT;
  assign issue_next_s = (state_s == RUN) && credit_s;

  // Next-state and issue-counter logic.
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    col_s   = col_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          row_s   = '0;
          col_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s) begin
          if (last_s) begin
            state_s = DRAIN;
          end else begin
            state_s = RUN;
          end
          if (col_r == CLW'(P - 1)) begin
            col_s = '0;
            if (row_r == RW'(M - 1)) begin
              row_s = '0;
            end else begin
              row_s = row_r + RW'(1);
            end
          end else begin
            col_s = col_r + CLW'(1);
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if ((inflight_s == '0) && (fifo_count_s == '0)) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      row_r         <= '0;
      col_r         <= '0;
      issue_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      inflight_r    <= '0;
      fifo_count_r  <= '0;
      res_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      row_r         <= row_s;
      col_r         <= col_s;
      issue_valid_r <= issue_next_s;
      busy_r        <= (state_s == RUN) || (state_s == DRAIN);
      done_r        <= (state_s == DONE);
      inflight_r    <= inflight_s;
      fifo_count_r  <= fifo_count_s;
      res_valid_r   <= (fifo_count_s != '0);
    end
  end

  // Tag shift register: stage LAT-1 lines up with the engine result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_valid_r[i] <= 1'b0;
        tag_row_r[i]   <= '0;
        tag_col_r[i]   <= '0;
      end
    end else begin
      tag_valid_r[0] <= issue_s;
      tag_row_r[0]   <= row_r;
      tag_col_r[0]   <= col_r;
      for (int i = 1; i < LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_row_r[i]   <= tag_row_r[i-1];
        tag_col_r[i]   <= tag_col_r[i-1];
      end
    end
  end

  // Result FIFO storage and pointers; credits guarantee a free slot on capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        mem_row_r[i]  <= '0;
        mem_col_r[i]  <= '0;
        mem_data_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (capture_s) begin
        mem_row_r[wr_ptr_r]  <= tag_row_r[LAT-1];
        mem_col_r[wr_ptr_r]  <= tag_col_r[LAT-1];
        mem_data_r[wr_ptr_r] <= eng_result;
        wr_ptr_r <= (wr_ptr_r == PW'(D - 1)) ? '0 : wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(D - 1)) ? '0 : rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign issue_valid = issue_valid_r;
  assign issue_row   = row_r;
  assign issue_col   = col_r;
  assign res_valid   = res_valid_r;
  assign res_row     = mem_row_r[rd_ptr_r];
  assign res_col     = mem_col_r[rd_ptr_r];
  assign res_data    = mem_data_r[rd_ptr_r];

endmodule

// File: tb/tb_matmul_dot_scheduler.sv
// Directed bench for matmul_dot_scheduler: a 2x3 LAT=2 instance with an engine
// model, plus a 1x1 LAT=1 instance for the back-to-back start corner.
module tb_matmul_dot_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, res_ready;
  logic       busy, done, issue_valid, res_valid;
  logic [0:0] issue_row, res_row;
  logic [1:0] issue_col, res_col;
  logic [7:0] eng_result, res_data;

  logic       start_b, res_ready_b;
  logic       busy_b, done_b, issue_valid_b, res_valid_b;
  logic [0:0] issue_row_b, issue_col_b, res_row_b, res_col_b;
  logic [7:0] eng_result_b, res_data_b;

  matmul_dot_scheduler #(.Nbits(4), .M(2), .P(3), .LAT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .issue_valid(issue_valid), .issue_row(issue_row), .issue_col(issue_col),
    .eng_result(eng_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_col(res_col), .res_data(res_data)
  );

  matmul_dot_scheduler #(.Nbits(4), .M(1), .P(1), .LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .issue_valid(issue_valid_b), .issue_row(issue_row_b), .issue_col(issue_col_b),
    .eng_result(eng_result_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_row(res_row_b), .res_col(res_col_b), .res_data(res_data_b)
  );

  // Engine models: A returns 10*row+col two cycles after issue, B returns 0x3C one cycle after.
  logic       pv1;
  logic [0:0] pr1;
  logic [1:0] pc1;
  always @(posedge clk) begin
    pv1          <= issue_valid;
    pr1          <= issue_row;
    pc1          <= issue_col;
    eng_result   <= pv1 ? (8'd10 * {7'd0, pr1} + {6'd0, pc1}) : 8'hEE;
    eng_result_b <= issue_valid_b ? 8'h3C : 8'hEE;
  end

  typedef struct { int cyc; int row; int col; int data; } ev_t;
  typedef struct { int row; int col; int data; int iss_off; int pop_off; } vec_t;

  ev_t  issue_q[$];
  ev_t  pop_q[$];
  int   iss_b[$];
  int   done_b_q[$];
  int   pop_b[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   done_busy = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl [6];

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder; cycle number n is the cycle that ends with posedge n.
  always @(negedge clk) begin
    if (issue_valid) issue_q.push_back('{cyc + 1, int'(issue_row), int'(issue_col), 0});
    if (res_valid && res_ready) pop_q.push_back('{cyc + 1, int'(res_row), int'(res_col), int'(res_data)});
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc + 1;
      done_busy <= int'(busy);
    end
    if (issue_valid_b) iss_b.push_back(cyc + 1);
    if (done_b) done_b_q.push_back(cyc + 1);
    if (res_valid_b && res_ready_b) pop_b.push_back(int'(res_data_b));
  end

  function automatic int pack(input int v, input int r, input int c, input int d);
    return v * 100000 + r * 10000 + c * 1000 + d;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; also checks that a stalled head stays valid and unchanged.
  task automatic step();
    bit hold;
    int hv;
    hold = reset && res_valid && !res_ready;
    hv   = pack(int'(res_valid), int'(res_row), int'(res_col), int'(res_data));
    @(posedge clk);
    #1;
    if (hold) check("head_hold", pack(int'(res_valid), int'(res_row), int'(res_col), int'(res_data)), hv);
  endtask

  task automatic clear_mon();
    issue_q.delete();
    pop_q.delete();
  endtask

  task automatic start_job(output int t);
    start = 1'b1;
    t = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input bit rnd);
    int i;
    i = 0;
    while (done_cnt == n0 && i < 300) begin
      if (rnd) res_ready = 1'($urandom_range(0, 1));
      step();
      i++;
    end
    check("done_seen", int'(done_cnt != n0), 1);
  endtask

  task automatic check_table(input int t, input bit timing);
    check("issue_count", issue_q.size(), 6);
    check("pop_count", pop_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < issue_q.size()) begin
        check("issue_entry", pack(1, issue_q[i].row, issue_q[i].col, 0), pack(1, tbl[i].row, tbl[i].col, 0));
        if (timing) check("issue_cycle", issue_q[i].cyc - t, tbl[i].iss_off);
      end
      if (i < pop_q.size()) begin
        check("pop_entry", pack(1, pop_q[i].row, pop_q[i].col, pop_q[i].data),
              pack(1, tbl[i].row, tbl[i].col, tbl[i].data));
        if (timing) check("pop_cycle", pop_q[i].cyc - t, tbl[i].pop_off);
      end
    end
    if (timing) begin
      check("done_cycle", done_cyc - t, 10);
      check("done_busy", done_busy, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_issue_valid"}, int'(issue_valid), 0);
    check({tag, "_issue_row"}, int'(issue_row), 0);
    check({tag, "_issue_col"}, int'(issue_col), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_row"}, int'(res_row), 0);
    check({tag, "_res_col"}, int'(res_col), 0);
    check({tag, "_res_data"}, int'(res_data), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, n0, rc, tb0;
    // {row, col, data, issue offset, pop offset} for M=2, P=3, LAT=2, ready high
    tbl[0] = '{0, 0, 0,  1, 4};
    tbl[1] = '{0, 1, 1,  2, 5};
    tbl[2] = '{0, 2, 2,  3, 6};
    tbl[3] = '{1, 0, 10, 4, 7};
    tbl[4] = '{1, 1, 11, 5, 8};
    tbl[5] = '{1, 2, 12, 6, 9};

    reset = 1'b0; start = 1'b0; res_ready = 1'b1;
    start_b = 1'b0; res_ready_b = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    // Full-rate job.
    clear_mon(); n0 = done_cnt;
    start_job(t);
    wait_done(n0, 1'b0);
    repeat (3) step();
    check("done_once", done_cnt - n0, 1);
    check_table(t, 1'b1);

    // Back-pressure: four issues fill the credits, then release.
    clear_mon(); n0 = done_cnt;
    res_ready = 1'b0;
    start_job(t);
    repeat (20) step();
    check("stall_issues", issue_q.size(), 4);
    check("stall_busy", int'(busy), 1);
    check("stall_head", pack(int'(res_valid), int'(res_row), int'(res_col), int'(res_data)), pack(1, 0, 0, 0));
    res_ready = 1'b1;
    rc = cyc + 1;
    wait_done(n0, 1'b0);
    repeat (3) step();
    check("done_once", done_cnt - n0, 1);
    if (issue_q.size() > 4) check("resume_cycle", issue_q[4].cyc - rc, 1);
    check_table(t, 1'b0);

    // Random back-pressure over many jobs.
    for (int j = 0; j < 200; j++) begin
      clear_mon(); n0 = done_cnt;
      start_job(t);
      wait_done(n0, 1'b1);
      res_ready = 1'b1;
      repeat (2) step();
      check("done_once", done_cnt - n0, 1);
      check_table(t, 1'b0);
    end

    // Reset asserted in the cycle of the third issue.
    clear_mon();
    start_job(t);
    step();
    step();
    reset = 1'b0;
    step();
    check_reset_outputs("midreset");
    check("midreset_issues", issue_q.size(), 3);
    reset = 1'b1;
    repeat (4) step();
    check("post_reset_idle", int'(res_valid), 0);
    clear_mon(); n0 = done_cnt;
    start_job(t);
    wait_done(n0, 1'b0);
    repeat (3) step();
    check("done_once", done_cnt - n0, 1);
    check_table(t, 1'b1);

    // start pulsed while running is ignored.
    clear_mon(); n0 = done_cnt;
    start_job(t);
    step();
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done(n0, 1'b0);
    repeat (4) step();
    check("done_once", done_cnt - n0, 1);
    check_table(t, 1'b1);

    // start held high on the 1x1 instance: two back-to-back jobs.
    start_b = 1'b1;
    tb0 = cyc + 1;
    repeat (6) step();
    start_b = 1'b0;
    repeat (15) step();
    check("b_issue_count", iss_b.size(), 2);
    check("b_done_count", done_b_q.size(), 2);
    check("b_pop_count", pop_b.size(), 2);
    if (iss_b.size() > 0) check("b_first_issue", iss_b[0] - tb0, 1);
    if (done_b_q.size() > 0) check("b_first_done", done_b_q[0] - tb0, 4);
    if (iss_b.size() > 1 && done_b_q.size() > 0) check("b_restart_gap", iss_b[1] - done_b_q[0], 2);
    if (done_b_q.size() > 1) check("b_second_done", done_b_q[1] - tb0, 9);
    for (int i = 0; i < pop_b.size(); i++) check("b_data", pop_b[i], 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
